mem_sram_ctrl: RTL
==================

// Module: mem_sram_ctrl
// PURPOSE
//  Sequences MEM-stage accesses to the data SRAM over a req/addr_ok/data_ok handshake.
//  Sits between EX/MEM and the data SRAM port. Generates byte strobes, lane-replicated store data
//  and sign/zero-extended load results. Holds the pipeline via stallreq until the access completes.
// PARAMETERS
//  WAIT_CNT_W  8  watchdog width; an access aborts after 2**WAIT_CNT_W-1 cycles in ADDR+DATA
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-high
//  flush            in   1   discard current access (pipeline flush)
//  req_valid        in   1   EX presents a memory op this cycle
//  req_we           in   1   1=store, 0=load
//  req_size         in   2   00=byte, 01=half, 10=word (11 treated as word)
//  req_sign         in   1   load sign-extend (lb/lh); ignored for stores/word
//  req_addr         in   32  byte address
//  req_wdata        in   32  store data, low-aligned
//  stallreq         out  1   to CTRL: hold pipeline
//  resp_valid       out  1   one-cycle pulse: access complete
//  resp_err         out  1   with resp_valid: timeout or misalignment
//  resp_rdata       out  32  extended load data (0 for stores/errors)
//  data_sram_req    out  1   SRAM request
//  data_sram_wr     out  1   SRAM write
//  data_sram_size   out  2   SRAM size
//  data_sram_wstrb  out  4   byte enables (0000 for loads)
//  data_sram_addr   out  32  SRAM address
//  data_sram_wdata  out  32  lane-replicated store data
//  data_sram_addr_ok in  1   SRAM accepted address
//  data_sram_data_ok in  1   SRAM finished; rdata valid
//  data_sram_rdata  in   32  SRAM read data
// BEHAVIOUR
//  - Reset: state=IDLE; all registered outputs 0; stallreq=0 while rst.
//  - FSM states: IDLE, ADDR, DATA, DRAIN, DONE.
//  - IDLE: req_valid&&!flush -> latch op, go ADDR; stallreq=req_valid&&!flush (combinational).
//  - ADDR: data_sram_req=1 with latched fields.
//    addr_ok&&data_ok -> DONE; addr_ok -> DATA; flush&&!addr_ok -> IDLE, no response.
//  - DATA: data_sram_req=0. data_ok -> DONE, capture rdata; flush -> DRAIN.
//  - DRAIN: wait data_ok, then IDLE; no resp_valid. flush ignored. Stray data_ok in IDLE ignored.
//  - DONE: resp_valid=1 for exactly one cycle, stallreq=0, req_valid ignored; next state IDLE.
//  - stallreq=1 in ADDR, DATA, DRAIN. Minimum latency: accept T, req T+1, addr_ok+data_ok T+1,
//    resp_valid T+2.
//  - Store strobes by addr[1:0]:
//    byte: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}};
//    half: wstrb=addr[1]?1100:0011, wdata={2{wdata[15:0]}};
//    word: wstrb=1111, wdata=wdata.
//  - Load extract: byte rdata[8*a+:8], half rdata[16*addr[1]+:16], word rdata.
//    Extend with req_sign.
//  - Watchdog counts cycles in ADDR/DATA and clears on entry to ADDR.
//    At 2**WAIT_CNT_W-1 -> DONE with resp_err=1, resp_rdata=0. A late data_ok is ignored.
//  - rst mid-access: next cycle IDLE, data_sram_req=0; outstanding SRAM response ignored.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: misaligned half (addr[0]) or word (addr[1:0]!=0) is not issued.
//    IDLE -> DONE directly; resp_err=1, resp_rdata=0, data_sram_req stays 0.
//  Undefined: low address bits are forced aligned (half &~1, word &~3) and the access proceeds
//    normally; resp_err only on timeout.
// TESTING
//  - sw addr=0x100 wdata=0xDEADBEEF, addr_ok+data_ok same cycle
//    -> wstrb=1111, req 1 cycle, resp_valid at T+2, err=0.
//  - sb addr=0x103 wdata=0x000000A5 -> wstrb=1000, data_sram_wdata=0xA5A5A5A5.
//  - lb addr=0x102 rdata=0x1280FF00, sign=1 -> resp_rdata=0xFFFFFF80;
//    lhu addr=0x102 -> 0x00001280.
//  - addr_ok after 3 cycles, data_ok 2 cycles later
//    -> stallreq high all 5 cycles plus the accept cycle, data_sram_req high only in ADDR.
//  - flush in DATA, data_ok 4 cycles later -> no resp_valid, stallreq high until data_ok, then IDLE.
//  - no addr_ok (WAIT_CNT_W=4) -> resp_err=1 after 15 cycles.
//    With MEM_ALIGN_CHECK_EN, lw addr=0x102 -> resp_err=1, no SRAM req.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage sequencer for the data SRAM (req/addr_ok/data_ok).
// Builds byte strobes and lane-replicated store data, extends load results,
// and holds the pipeline through stallreq while an access is in flight.
// Optional build macro: MEM_ALIGN_CHECK_EN (reject misaligned half/word).
//
// Handshake: data_sram_req is held while in ADDR; the address phase ends on
// the cycle data_sram_addr_ok is seen high, the data phase ends on the cycle
// data_sram_data_ok is seen high (both may coincide). resp_valid is a single
// cycle pulse with no back-pressure; resp_err/resp_rdata are valid only with it.
module mem_sram_ctrl #(
  parameter int WAIT_CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_e;

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic [31:0] load_ext;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic        timeout;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  // Normalise the incoming op: size 11 behaves as word, low address bits forced aligned.
  always_comb begin
    in_size = (req_size == 2'b11) ? 2'b10 : req_size;
    in_addr = req_addr;
    if (in_size == 2'b01) in_addr[0] = 1'b0;
    if (in_size == 2'b10) in_addr[1:0] = 2'b00;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((in_size == 2'b01) && req_addr[0]) ||
                      ((in_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

  // Load extraction and extension from the latched op.
  always_comb begin
    lane8    = data_sram_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane16   = data_sram_rdata[{addr_q[1], 4'b0000} +: 16];
    load_ext = data_sram_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{sign_q & lane8[7]}}, lane8};
      2'b01:   load_ext = {{16{sign_q & lane16[15]}}, lane16};
      default: load_ext = data_sram_rdata;
    endcase
  end

  // Store strobes and lane-replicated data from the latched op.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = wdata_q;
    case (size_q)
      2'b00: begin
        st_wstrb = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  assign timeout = (cnt_q >= CNT_LAST);

  // Next-state, op latch, watchdog and response capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          we_d    = req_we;
          size_d  = in_size;
          sign_d  = req_sign;
          addr_d  = in_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_ADDR;
          end
`else
          state_d = S_ADDR;
`endif
        end
      end
      S_ADDR: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (data_sram_addr_ok && data_sram_data_ok) begin
          state_d = S_DONE;
          rdata_d = we_q ? 32'd0 : load_ext;
        end else if (data_sram_addr_ok) begin
          state_d = S_DATA;
        end else if (flush) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (data_sram_data_ok) begin
          state_d = S_DONE;
          rdata_d = we_q ? 32'd0 : load_ext;
        end else if (flush) begin
          state_d = S_DRAIN;
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (data_sram_data_ok) state_d = S_IDLE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs: SRAM fields only while requesting; stall covers accept through drain.
  always_comb begin
    data_sram_req   = !rst && (state_q == S_ADDR);
    data_sram_wr    = data_sram_req && we_q;
    data_sram_size  = data_sram_req ? size_q : 2'b00;
    data_sram_addr  = data_sram_req ? addr_q : 32'd0;
    data_sram_wdata = data_sram_req ? st_wdata : 32'd0;
    data_sram_wstrb = data_sram_wr ? st_wstrb : 4'b0000;
    resp_valid      = (state_q == S_DONE);
    resp_err        = err_q;
    resp_rdata      = rdata_q;
    stallreq        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE:                  stallreq = req_valid && !flush;
        S_ADDR, S_DATA, S_DRAIN: stallreq = 1'b1;
        default:                 stallreq = 1'b0;
      endcase
    end
  end

endmodule
